// File: rtl/zx48_clock_ctrl.sv
// ---------------------------------------------------------------------------
// zx48_clock_ctrl
//
// Clock sequencer for the ZX48 Z80 core. Divides the master clock into CPU
// T-states and issues one pe/ne clock-enable pair per T-state. Tracks the
// ULA raster position (hc/vc), generates the frame interrupt (mi) and applies
// 48K memory contention by withholding whole T-states while the CPU presents
// a contended address during the display fetch window.
//
// Parameters
//   CLKDIV   master clocks per T-state (even, >= 4)
//   LINE_T   T-states per raster line
//   LINES    raster lines per frame
//   INT_LEN  T-states for which mi is held low at frame start
//
// Ports
//   clock    in   master clock, the only clock
//   reset    in   synchronous, active-high reset
//   a        in   CPU address bus
//   mreq     in   CPU MREQ_n (active low)
//   iorq     in   CPU IORQ_n (active low)
//   rfsh     in   CPU RFSH_n (active low)
//   pe       out  CPU positive-edge enable, one clock wide
//   ne       out  CPU negative-edge enable, one clock wide
//   mi       out  INT_n to the CPU, active low
//   hc       out  T-state within the current line
//   vc       out  line within the current frame
//   stall    out  high for every withheld T-state
//
// Optional feature
//   ZX48_CONTENTION_IO_EN  when defined, ULA port accesses (a[0]==0) are
//                          contended in the window like memory accesses.
// ---------------------------------------------------------------------------
module zx48_clock_ctrl #(
   parameter int CLKDIV  = 4,
   parameter int LINE_T  = 224,
   parameter int LINES   = 312,
   parameter int INT_LEN = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic        mreq,
   input  logic        iorq,
   input  logic        rfsh,
   output logic        pe,
   output logic        ne,
   output logic        mi,
   output logic [7:0]  hc,
   output logic [8:0]  vc,
   output logic        stall
);

   localparam int            PW      = $clog2(CLKDIV);
   localparam logic [PW-1:0] PH_LAST = PW'(CLKDIV - 1);
   localparam logic [PW-1:0] PH_NE   = PW'(CLKDIV / 2 - 1);
   localparam logic [7:0]    HC_LAST = 8'(LINE_T - 1);
   localparam logic [8:0]    VC_LAST = 9'(LINES - 1);

   logic [PW-1:0] ph_q, ph_d;
   logic [7:0]    hc_q, hc_d;
   logic [8:0]    vc_q, vc_d;
   logic          pe_q, pe_d;
   logic          ne_q, ne_d;
   logic          mi_q, mi_d;
   logic          stall_q, stall_d;
   logic          en_q, en_d;
   logic          intArmed_q, intArmed_d;

   logic          phLast;
   logic [7:0]    hcNext;
   logic [8:0]    vcNext;
   logic          win;
   logic          cacc;
   logic          stallNext;
   logic          frameStart;
   logic          unusedBits;

   // Raster position and contention decision for the T-state that begins at
   // the next phase wrap. The window and the 6,5,4,3,2,1,0,0 pattern are both
   // judged on that coming T-state, so a stall lands exactly where the
   // contended T-state sits in the raster.
   always_comb begin
      phLast     = (ph_q == PH_LAST);
      hcNext     = (hc_q == HC_LAST) ? 8'd0 : hc_q + 8'd1;
      vcNext     = vc_q;
      if (hc_q == HC_LAST) begin
         vcNext = (vc_q == VC_LAST) ? 9'd0 : vc_q + 9'd1;
      end
      win        = (vcNext >= 9'd64) && (vcNext <= 9'd255) && (hcNext <= 8'd127);
      cacc       = (a[15:14] == 2'b01) && mreq && rfsh;
`ifdef ZX48_CONTENTION_IO_EN
      cacc       = cacc || (iorq && !a[0] && mreq);
`endif
      stallNext  = win && (hcNext[2:0] < 3'd6) && cacc;
      frameStart = (hcNext == 8'd0) && (vcNext == 9'd0);
   end

   // Bus bits that play no part in the contention decision for this build.
`ifdef ZX48_CONTENTION_IO_EN
   assign unusedBits = ^a[13:1];
`else
   assign unusedBits = ^{a[13:0], iorq};
`endif

   // Next-state logic. Everything that belongs to a T-state (raster position,
   // stall flag, enable permission, interrupt level) changes only at the phase
   // wrap. pe is produced at that same wrap so it coincides with ph==0, and ne
   // is gated by the permission latched at the start of its own T-state, which
   // keeps the pair together. The interrupt is armed by the first frame start
   // seen after reset, so mi stays high until the raster returns to 0,0.
   always_comb begin
      ph_d       = phLast ? '0 : ph_q + PW'(1);
      hc_d       = hc_q;
      vc_d       = vc_q;
      stall_d    = stall_q;
      en_d       = en_q;
      mi_d       = mi_q;
      intArmed_d = intArmed_q;
      pe_d       = phLast && !stallNext;
      ne_d       = (ph_q == PH_NE) && en_q;
      if (phLast) begin
         hc_d       = hcNext;
         vc_d       = vcNext;
         stall_d    = stallNext;
         en_d       = !stallNext;
         intArmed_d = intArmed_q || frameStart;
         mi_d       = !((intArmed_q || frameStart) && (vcNext == 9'd0) &&
                        (int'(hcNext) < INT_LEN));
      end
   end

   // State register. Reset abandons any stall in progress and restarts the
   // phase and raster counters; the T-state right after reset is not enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         ph_q       <= '0;
         hc_q       <= 8'd0;
         vc_q       <= 9'd0;
         pe_q       <= 1'b0;
         ne_q       <= 1'b0;
         mi_q       <= 1'b1;
         stall_q    <= 1'b0;
         en_q       <= 1'b0;
         intArmed_q <= 1'b0;
      end else begin
         ph_q       <= ph_d;
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         pe_q       <= pe_d;
         ne_q       <= ne_d;
         mi_q       <= mi_d;
         stall_q    <= stall_d;
         en_q       <= en_d;
         intArmed_q <= intArmed_d;
      end
   end

   assign pe    = pe_q;
   assign ne    = ne_q;
   assign mi    = mi_q;
   assign hc    = hc_q;
   assign vc    = vc_q;
   assign stall = stall_q;

endmodule
